// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU register bank: widths, write-port priority
// encoding and the load-tracker state type.
package cpu_pkg;

    localparam int OPCODE_W     = 4;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 64;
    localparam int LAT_CNT_W    = 4;   // holds LOAD_LAT values 1..15

    // Which write port owns a register in a given cycle.
    typedef enum logic [1:0] {
        WR_NONE,
        WR_LD,
        WR_ALU,
        WR_LOAD
    } wr_src_e;

    // Load-tracker states.
    typedef enum logic {
        IDLE,
        WAIT
    } lt_state_e;

    // Resolve colliding writes to one register: load return > ALU > immediate.
    function automatic wr_src_e pick_wr_src(input logic hit_load,
                                            input logic hit_alu,
                                            input logic hit_ld);
        if (hit_load)     return WR_LOAD;
        else if (hit_alu) return WR_ALU;
        else if (hit_ld)  return WR_LD;
        else              return WR_NONE;
    endfunction

endpackage

// File: rtl/load_tracker.sv
// Tracks the single outstanding memory load: counts return latency, holds the
// pending destination, and flags read-after-load hazards.
module load_tracker
    import cpu_pkg::*;
#(
    parameter int AW       = 6,
    parameter int LOAD_LAT = 3
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          start,
    input  logic [AW-1:0] dst_in,
    input  logic [AW-1:0] src_in,
    input  logic [AW-1:0] src2_in,
    output logic          load_busy,
    output logic          capture,
    output logic [AW-1:0] pdst,
    output logic          hazard
);

    lt_state_e            state;
    logic [LAT_CNT_W-1:0] cnt;

    // Load FSM: latch destination on start, count cycles until data returns.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!RST) begin
            state <= IDLE;
            cnt   <= '0;
            pdst  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pdst  <= dst_in;
                        cnt   <= LAT_CNT_W'(1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == LAT_CNT_W'(LOAD_LAT)) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + LAT_CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign load_busy = (state == WAIT);
    assign capture   = load_busy && (cnt == LAT_CNT_W'(LOAD_LAT));
    assign hazard    = load_busy && ((src_in == pdst) || (src2_in == pdst));

endmodule

// File: rtl/bank_register_param.sv
// Parametrised CPU register bank with ALU read-port bypass, single outstanding
// memory load, optional hard-wired zero register and fixed write priority.
module bank_register_param
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int LOAD_LAT = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                RST,
    input  logic [DATA_W-1:0]   DATA_IN,
    input  logic [DATA_W-1:0]   result,
    input  logic [AW-1:0]       src_in,
    input  logic [AW-1:0]       src2_in,
    input  logic [AW-1:0]       dst_in,
    input  logic [AW-1:0]       dstLd_in,
    input  logic [DATA_W-2:0]   const_in,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                ld,
    input  logic                write,
    input  logic                read,
    input  logic                write_ALU,
    output logic [DATA_W-1:0]   src_alu,
    output logic [DATA_W-1:0]   src2_alu,
    output logic [OPCODE_W-1:0] ctrl_alu,
    output logic [DATA_W-1:0]   DATA_OUT,
    output logic [DATA_W-1:0]   DADDR,
    output logic                DWR,
    output logic                DRD,
    output logic                load_busy,
    output logic                hazard
);

    localparam bit ZR  = (ZERO_REG != 0);
    localparam bit BYP = (BYPASS != 0);

    logic [DATA_W-1:0] regs     [NUM_REGS];
    logic [DATA_W-1:0] regs_nxt [NUM_REGS];
    logic [DATA_W-1:0] ld_val;
    logic [DATA_W-1:0] port_a;
    logic [DATA_W-1:0] port_b;
    logic [AW-1:0]     pdst;
    logic              capture;
    logic              load_start;
    logic              ld_we;
    logic              alu_we;
    logic              ret_we;

    // A store owns DADDR, so a read in the same cycle never starts a load.
    assign load_start = read && !write && !load_busy;
    assign ld_val     = {1'b0, const_in};

    assign ld_we  = ld        && !(ZR && (dstLd_in == '0));
    assign alu_we = write_ALU && !(ZR && (dst_in   == '0));
    assign ret_we = capture   && !(ZR && (pdst     == '0));

    load_tracker #(
        .AW       (AW),
        .LOAD_LAT (LOAD_LAT)
    ) u_load_tracker (
        .clk       (clk),
        .RST       (RST),
        .start     (load_start),
        .dst_in    (dst_in),
        .src_in    (src_in),
        .src2_in   (src2_in),
        .load_busy (load_busy),
        .capture   (capture),
        .pdst      (pdst),
        .hazard    (hazard)
    );

    // Next register-file contents after resolving all write ports by priority.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            // NOTE: default every element first so no path leaves it unassigned
            // and a latch cannot be inferred.
            regs_nxt[i] = regs[i];
            case (pick_wr_src(ret_we && (pdst     == AW'(i)),
                              alu_we && (dst_in   == AW'(i)),
                              ld_we  && (dstLd_in == AW'(i))))
                WR_LOAD: regs_nxt[i] = DATA_IN;
                WR_ALU:  regs_nxt[i] = result;
                WR_LD:   regs_nxt[i] = ld_val;
                default: regs_nxt[i] = regs[i];
            endcase
        end
    end

    // Operand selection: post-write view when bypassing, zero for reg 0 if hard-wired.
    assign port_a = (ZR && (src_in  == '0)) ? '0 : (BYP ? regs_nxt[src_in]  : regs[src_in]);
    assign port_b = (ZR && (src2_in == '0)) ? '0 : (BYP ? regs_nxt[src2_in] : regs[src2_in]);

    // Register file update.
    // NOTE: the array is cleared on reset because the bank must read back zero
    // after reset; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (!RST) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= regs_nxt[i];
        end
    end

    // Registered ALU operands and memory-interface outputs.
    always_ff @(posedge clk) begin
        if (!RST) begin
            src_alu  <= '0;
            src2_alu <= '0;
            ctrl_alu <= '0;
            DATA_OUT <= '0;
            DADDR    <= '0;
            DWR      <= 1'b0;
            DRD      <= 1'b0;
        end else begin
            src_alu  <= port_a;
            src2_alu <= port_b;
            ctrl_alu <= opcode;
            DWR      <= write;
            DRD      <= load_start;
            if (write)     DATA_OUT <= regs[src_in];
            else if (ld)   DATA_OUT <= ld_val;
            if (write || load_start) DADDR <= regs[src2_in];
        end
    end

endmodule

// File: tb/tb_bank_register_param.sv
// Self-checking bench for bank_register_param: two instances (bypass on /
// zero-reg off / latency 3, and bypass off / zero-reg on / latency 5) driven
// by identical directed and random stimulus, compared against a behavioural model.
module tb_bank_register_param;

    localparam int DW = 32;
    localparam int NR = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          RST;
    logic [DW-1:0] DATA_IN, result;
    logic [AW-1:0] src_in, src2_in, dst_in, dstLd_in;
    logic [DW-2:0] const_in;
    logic [3:0]    opcode;
    logic          ld, write, read, write_ALU;

    logic [DW-1:0] a_src_alu, a_src2_alu, a_data_out, a_daddr;
    logic [3:0]    a_ctrl_alu;
    logic          a_dwr, a_drd, a_load_busy, a_hazard;
    logic [DW-1:0] b_src_alu, b_src2_alu, b_data_out, b_daddr;
    logic [3:0]    b_ctrl_alu;
    logic          b_dwr, b_drd, b_load_busy, b_hazard;

    always #5 clk = ~clk;

    bank_register_param #(.DATA_W(DW), .NUM_REGS(NR), .LOAD_LAT(3), .ZERO_REG(0), .BYPASS(1)) dut_a (
        .clk(clk), .RST(RST), .DATA_IN(DATA_IN), .result(result),
        .src_in(src_in), .src2_in(src2_in), .dst_in(dst_in), .dstLd_in(dstLd_in),
        .const_in(const_in), .opcode(opcode), .ld(ld), .write(write), .read(read),
        .write_ALU(write_ALU), .src_alu(a_src_alu), .src2_alu(a_src2_alu),
        .ctrl_alu(a_ctrl_alu), .DATA_OUT(a_data_out), .DADDR(a_daddr), .DWR(a_dwr),
        .DRD(a_drd), .load_busy(a_load_busy), .hazard(a_hazard)
    );

    bank_register_param #(.DATA_W(DW), .NUM_REGS(NR), .LOAD_LAT(5), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .RST(RST), .DATA_IN(DATA_IN), .result(result),
        .src_in(src_in), .src2_in(src2_in), .dst_in(dst_in), .dstLd_in(dstLd_in),
        .const_in(const_in), .opcode(opcode), .ld(ld), .write(write), .read(read),
        .write_ALU(write_ALU), .src_alu(b_src_alu), .src2_alu(b_src2_alu),
        .ctrl_alu(b_ctrl_alu), .DATA_OUT(b_data_out), .DADDR(b_daddr), .DWR(b_dwr),
        .DRD(b_drd), .load_busy(b_load_busy), .hazard(b_hazard)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit model_valid = 1'b0;

    // Reference model state, index 0 = dut_a, 1 = dut_b.
    logic [DW-1:0] m_regs [2][NR];
    logic [DW-1:0] m_src [2], m_src2 [2], m_dout [2], m_daddr [2];
    logic [3:0]    m_ctrl [2];
    logic          m_dwr [2], m_drd [2], m_busy [2];
    int            m_rem [2];
    logic [AW-1:0] m_pdst [2];

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 3 : 5;
    endfunction

    function automatic logic exp_hazard(input int k);
        return m_busy[k] && ((src_in == m_pdst[k]) || (src2_in == m_pdst[k]));
    endfunction

    // One clock edge of the architectural behaviour for instance k.
    task automatic model_step(input int k);
        logic [DW-1:0] nxt [NR];
        bit zr, byp, cap;
        zr  = (k == 1);
        byp = (k == 0);
        if (!RST) begin
            for (int i = 0; i < NR; i++) m_regs[k][i] = '0;
            m_src[k] = '0; m_src2[k] = '0; m_dout[k] = '0; m_daddr[k] = '0;
            m_ctrl[k] = '0; m_dwr[k] = 1'b0; m_drd[k] = 1'b0; m_busy[k] = 1'b0;
            m_rem[k] = 0; m_pdst[k] = '0;
            return;
        end
        for (int i = 0; i < NR; i++) nxt[i] = m_regs[k][i];
        cap = m_busy[k] && (m_rem[k] == 1);
        // Apply writes lowest priority first so higher priority overwrites.
        if (ld && !(zr && dstLd_in == 0))       nxt[dstLd_in]  = {1'b0, const_in};
        if (write_ALU && !(zr && dst_in == 0))  nxt[dst_in]    = result;
        if (cap && !(zr && m_pdst[k] == 0))     nxt[m_pdst[k]] = DATA_IN;
        m_src[k]  = (zr && src_in  == 0) ? '0 : (byp ? nxt[src_in]  : m_regs[k][src_in]);
        m_src2[k] = (zr && src2_in == 0) ? '0 : (byp ? nxt[src2_in] : m_regs[k][src2_in]);
        m_ctrl[k] = opcode;
        if (write)   m_dout[k] = m_regs[k][src_in];
        else if (ld) m_dout[k] = {1'b0, const_in};
        if (write || (read && !m_busy[k])) m_daddr[k] = m_regs[k][src2_in];
        m_dwr[k] = write;
        m_drd[k] = read && !write && !m_busy[k];
        if (m_drd[k]) begin
            m_busy[k] = 1'b1;
            m_rem[k]  = lat_of(k);
            m_pdst[k] = dst_in;
        end else if (cap) begin
            m_busy[k] = 1'b0;
        end else if (m_busy[k]) begin
            m_rem[k] = m_rem[k] - 1;
        end
        for (int i = 0; i < NR; i++) m_regs[k][i] = nxt[i];
    endtask

    task automatic compare_outputs();
        check("a.src_alu",   a_src_alu,         m_src[0]);
        check("a.src2_alu",  a_src2_alu,        m_src2[0]);
        check("a.ctrl_alu",  32'(a_ctrl_alu),   32'(m_ctrl[0]));
        check("a.DATA_OUT",  a_data_out,        m_dout[0]);
        check("a.DADDR",     a_daddr,           m_daddr[0]);
        check("a.DWR",       32'(a_dwr),        32'(m_dwr[0]));
        check("a.DRD",       32'(a_drd),        32'(m_drd[0]));
        check("a.load_busy", 32'(a_load_busy),  32'(m_busy[0]));
        check("b.src_alu",   b_src_alu,         m_src[1]);
        check("b.src2_alu",  b_src2_alu,        m_src2[1]);
        check("b.ctrl_alu",  32'(b_ctrl_alu),   32'(m_ctrl[1]));
        check("b.DATA_OUT",  b_data_out,        m_dout[1]);
        check("b.DADDR",     b_daddr,           m_daddr[1]);
        check("b.DWR",       32'(b_dwr),        32'(m_dwr[1]));
        check("b.DRD",       32'(b_drd),        32'(m_drd[1]));
        check("b.load_busy", 32'(b_load_busy),  32'(m_busy[1]));
    endtask

    // Inputs are set at the falling edge; check hazard, clock, then compare.
    task automatic tick();
        #1;
        if (model_valid) begin
            check("a.hazard", 32'(a_hazard), 32'(exp_hazard(0)));
            check("b.hazard", 32'(b_hazard), 32'(exp_hazard(1)));
        end
        @(posedge clk);
        model_step(0);
        model_step(1);
        model_valid = 1'b1;
        #1;
        compare_outputs();
        @(negedge clk);
    endtask

    task automatic idle();
        RST = 1'b1; ld = 1'b0; write = 1'b0; read = 1'b0; write_ALU = 1'b0;
    endtask

    initial begin
        RST = 1'b0; ld = 1'b0; write = 1'b0; read = 1'b0; write_ALU = 1'b0;
        DATA_IN = '0; result = '0; src_in = '0; src2_in = '0; dst_in = '0;
        dstLd_in = '0; const_in = '0; opcode = '0;
        @(negedge clk);
        tick();
        tick();

        // Reset with registers pre-loaded.
        idle(); ld = 1'b1; dstLd_in = 6'd5; const_in = 31'h55; tick();
        idle(); RST = 1'b0; tick(); tick();
        check("rst.DATA_OUT", a_data_out, 32'h0);
        idle(); src_in = 6'd5; tick();
        check("rst.reg5", a_src_alu, 32'h0);

        // Load immediate then read it back.
        idle(); ld = 1'b1; dstLd_in = 6'd7; const_in = 31'h12345678; tick();
        check("ld.DATA_OUT", a_data_out, 32'h12345678);
        idle(); src_in = 6'd7; tick();
        check("ld.src_alu", a_src_alu, 32'h12345678);

        // Same-cycle ALU writeback and read of the same register.
        idle(); write_ALU = 1'b1; dst_in = 6'd3; result = 32'hDEADBEEF; src_in = 6'd3; tick();
        check("byp.on",  a_src_alu, 32'hDEADBEEF);
        check("byp.off", b_src_alu, 32'h0);

        // Load with pending hazard, ignored second read and return collision.
        idle(); ld = 1'b1; dstLd_in = 6'd2; const_in = 31'h100; tick();
        idle(); read = 1'b1; src2_in = 6'd2; dst_in = 6'd9; src_in = 6'd0; tick();
        check("load.DADDR", a_daddr, 32'h100);
        check("load.DRD",   32'(a_drd), 32'h1);
        idle(); read = 1'b1; src_in = 6'd9; src2_in = 6'd3; dst_in = 6'd12;
        #1 check("load.hazard", 32'(a_hazard), 32'h1);
        tick();
        check("load.2nd_DRD",   32'(a_drd), 32'h0);
        check("load.2nd_DADDR", a_daddr, 32'h100);
        idle(); DATA_IN = 32'hA5A5A5A5; src_in = 6'd0; tick();
        idle(); write_ALU = 1'b1; dst_in = 6'd9; result = 32'h77; src_in = 6'd9; tick();
        check("coll.load_wins", a_src_alu, 32'hA5A5A5A5);
        check("load.busy_done", 32'(a_load_busy), 32'h0);
        idle(); src_in = 6'd9; tick();
        check("coll.reg9", a_src_alu, 32'hA5A5A5A5);
        idle(); tick(); tick(); tick();

        // ALU beats load-immediate on the same register.
        idle(); ld = 1'b1; dstLd_in = 6'd4; const_in = 31'h1111;
        write_ALU = 1'b1; dst_in = 6'd4; result = 32'h2222; tick();
        idle(); src_in = 6'd4; tick();
        check("coll.reg4", a_src_alu, 32'h2222);

        // Store and read together: store proceeds, load never starts.
        idle(); write = 1'b1; read = 1'b1; src_in = 6'd7; src2_in = 6'd2; dst_in = 6'd20; tick();
        check("st.DATA_OUT", a_data_out, 32'h12345678);
        check("st.DWR",      32'(a_dwr), 32'h1);
        check("st.DRD",      32'(a_drd), 32'h0);
        check("st.busy",     32'(a_load_busy), 32'h0);
        idle(); tick();
        check("st.DWR_pulse", 32'(a_dwr), 32'h0);

        // Reset one cycle after the load strobe discards the load.
        idle(); read = 1'b1; src2_in = 6'd2; dst_in = 6'd10; tick();
        idle(); RST = 1'b0; tick();
        check("rstld.busy", 32'(a_load_busy), 32'h0);
        idle(); DATA_IN = 32'hFFFFFFFF;
        for (int i = 0; i < 6; i++) tick();
        idle(); src_in = 6'd10; tick();
        check("rstld.reg10", a_src_alu, 32'h0);

        // Random traffic, addresses biased to a small window to force collisions.
        for (int n = 0; n < 1500; n++) begin
            RST       = ($urandom_range(0, 99) != 0);
            ld        = ($urandom_range(0, 3) == 0);
            write     = ($urandom_range(0, 5) == 0);
            read      = ($urandom_range(0, 3) == 0);
            write_ALU = ($urandom_range(0, 2) == 0);
            src_in    = ($urandom_range(0, 3) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
            src2_in   = ($urandom_range(0, 3) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
            dst_in    = ($urandom_range(0, 3) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
            dstLd_in  = ($urandom_range(0, 3) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
            const_in  = 31'($urandom);
            result    = $urandom;
            DATA_IN   = $urandom;
            opcode    = 4'($urandom_range(0, 15));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
